bench_sig_reg: RTL and testbench

- Parametrised successor to the generic XOR-accumulating sequential benchmark: a W-bit signature register with selectable update mode (legacy XOR accumulate, MISR, autonomous LFSR, hold).
- Adds a programmable capture window, a start/abort control FSM, a one-cycle done pulse and a golden-signature compare.
- Sits in the benchmark set as a trojan-detection / response-compaction element beside the plain benchmark circuits.

---
 rtl/bench_seq_pkg.sv | 21 ++
 rtl/bench_sig_reg_if.sv | 29 ++
 rtl/bench_sig_update.sv | 32 +++
 rtl/bench_sig_reg.sv | 92 +++++++++
 tb/tb_bench_sig_reg.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/bench_seq_pkg.sv
// Shared types and constants for the sequential signature benchmarks.
// Mode encoding matches the 2-bit mode input.
package bench_seq_pkg;

  typedef enum logic [1:0] {
    MODE_XOR  = 2'b00,
    MODE_MISR = 2'b01,
    MODE_LFSR = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Fibonacci taps for the 8-bit maximal-length polynomial
  localparam logic [7:0] DEFAULT_POLY = 8'hB8;

endpackage

// File: rtl/bench_sig_reg_if.sv
// Control, data and status bundle of the signature register.
// The master drives the window controls and the slave reports the signature.
interface bench_sig_reg_if #(
  parameter int W  = 8,
  parameter int CW = 8
);
  logic          start;
  logic          abort;
  logic [1:0]    mode;
  logic [W-1:0]  seed;
  logic [CW-1:0] window_len;
  logic [W-1:0]  data_in;
  logic          data_valid;
  logic [W-1:0]  golden;
  logic [W-1:0]  sig_out;
  logic          busy;
  logic          done;
  logic          match;

  modport master (
    output start, abort, mode, seed, window_len, data_in, data_valid, golden,
    input  sig_out, busy, done, match
  );

  modport slave (
    input  start, abort, mode, seed, window_len, data_in, data_valid, golden,
    output sig_out, busy, done, match
  );
endinterface

// File: rtl/bench_sig_update.sv
// Combinational next-signature function for XOR, MISR, LFSR and HOLD modes.
// Feedback is the parity of the tapped signature bits, shifted in at bit 0.
module bench_sig_update
  import bench_seq_pkg::*;
#(
  parameter int           W    = 8,
  parameter logic [W-1:0] POLY = W'(DEFAULT_POLY)
) (
  input  logic [W-1:0] sig,
  input  logic [W-1:0] data_in,
  input  mode_e        mode,
  output logic [W-1:0] next_sig
);

  logic         fb;
  logic [W-1:0] shifted;

  assign fb      = ^(sig & POLY);
  assign shifted = {sig[W-2:0], fb};

  always_comb begin
    next_sig = sig;
    case (mode)
      MODE_XOR:  next_sig = sig ^ data_in;
      MODE_MISR: next_sig = shifted ^ data_in;
      MODE_LFSR: next_sig = shifted;
      MODE_HOLD: next_sig = sig;
      default:   next_sig = sig;
    endcase
  end

endmodule

// File: rtl/bench_sig_reg.sv
// Signature register with a counted capture window, abort, done pulse
// and a golden-signature compare registered while in DONE.
module bench_sig_reg
  import bench_seq_pkg::*;
#(
  parameter int           W    = 8,
  parameter logic [W-1:0] POLY = W'(DEFAULT_POLY),
  parameter int           CW   = 8
) (
  input logic            clk,
  input logic            reset,
  bench_sig_reg_if.slave bus
);

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [W-1:0]  sig_q, sig_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          match_q, match_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  next_sig;

  bench_sig_update #(.W(W), .POLY(POLY)) u_update (
    .sig      (sig_q),
    .data_in  (bus.data_in),
    .mode     (mode_q),
    .next_sig (next_sig)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    match_d = match_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sig_d   = bus.seed;
          cnt_d   = bus.window_len;
          mode_d  = mode_e'(bus.mode);
          match_d = 1'b0;
          state_d = (bus.window_len != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        // abort wins over a concurrent final update
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.data_valid) begin
          sig_d = next_sig;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        match_d = (sig_q == bus.golden);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_XOR;
      sig_q   <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.sig_out = sig_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.match   = match_q;

endmodule

// File: tb/tb_bench_sig_reg.sv
// Randomized window-level bench for bench_sig_reg with directed scenarios first.
// Expected signatures come from a per-word reference of the four update rules.
module tb_bench_sig_reg;

  localparam int         W    = 8;
  localparam int         CW   = 8;
  localparam logic [7:0] POLY = 8'hB8;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] last_sig;
  logic [7:0] dq[$];
  bit         vq[$];

  bench_sig_reg_if #(.W(W), .CW(CW)) bus_if ();

  bench_sig_reg #(.W(W), .POLY(POLY), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_next(input logic [1:0] m, input logic [7:0] s, input logic [7:0] d);
    int         ones;
    logic [7:0] shifted;
    ones    = $countones(s & POLY);
    shifted = 8'((int'(s) * 2) % 256 + (ones % 2));
    case (m)
      2'd0:    return s ^ d;
      2'd1:    return shifted ^ d;
      2'd2:    return shifted;
      default: return s;
    endcase
  endfunction

  // One complete window; abort_at is the valid beat index carrying abort (-1: none),
  // gold < 0 picks a random golden (half the time the correct one).
  task automatic run_window(input logic [1:0] m, input logic [7:0] seed, input int len,
                            input int abort_at, input int gold);
    logic [7:0] exp;
    logic [7:0] d;
    logic [7:0] g;
    int         beats;
    int         cyc;
    bit         v;
    bit         ab;
    @(negedge clk);
    bus_if.start      = 1'b1;
    bus_if.mode       = m;
    bus_if.seed       = seed;
    bus_if.window_len = len[7:0];
    bus_if.abort      = 1'($urandom_range(0, 1));
    bus_if.data_valid = 1'($urandom_range(0, 1));
    bus_if.data_in    = 8'($urandom);
    @(negedge clk);
    exp   = seed;
    beats = 0;
    cyc   = 0;
    ab    = 1'b0;
    check("sig_load", bus_if.sig_out, exp);
    check("match_clr", bus_if.match, 0);
    if (len != 0) begin
      check("busy_start", bus_if.busy, 1);
      check("done_start", bus_if.done, 0);
      while (beats < len) begin
        if (cyc > 4000) begin
          check("timeout_beats", beats, len);
          break;
        end
        cyc++;
        v  = (vq.size() != 0) ? vq.pop_front() : ($urandom_range(0, 3) != 0);
        d  = (dq.size() != 0) ? dq.pop_front() : 8'($urandom);
        ab = v && (beats == abort_at);
        bus_if.start      = 1'($urandom_range(0, 1));
        bus_if.mode       = 2'($urandom);
        bus_if.seed       = 8'($urandom);
        bus_if.window_len = 8'($urandom);
        bus_if.data_valid = v;
        bus_if.data_in    = d;
        bus_if.abort      = ab;
        @(negedge clk);
        if (ab) break;
        if (v) begin
          exp = ref_next(m, exp, d);
          beats++;
        end
        check("sig_upd", bus_if.sig_out, exp);
        check("busy_run", bus_if.busy, beats < len);
        check("done_run", bus_if.done, beats == len);
      end
      bus_if.start      = 1'b0;
      bus_if.abort      = 1'b0;
      bus_if.data_valid = 1'b0;
      if (ab) begin
        check("abort_busy", bus_if.busy, 0);
        check("abort_done", bus_if.done, 0);
        check("abort_sig", bus_if.sig_out, exp);
        @(negedge clk);
        check("abort_done2", bus_if.done, 0);
        check("abort_match", bus_if.match, 0);
        check("abort_sig2", bus_if.sig_out, exp);
        last_sig = exp;
        dq.delete();
        vq.delete();
        return;
      end
    end else begin
      check("busy_len0", bus_if.busy, 0);
      check("done_len0", bus_if.done, 1);
    end
    g = (gold < 0) ? (($urandom_range(0, 1) != 0) ? exp : 8'($urandom)) : gold[7:0];
    bus_if.golden     = g;
    bus_if.start      = 1'($urandom_range(0, 1));
    bus_if.abort      = 1'($urandom_range(0, 1));
    bus_if.data_valid = 1'b0;
    @(negedge clk);
    bus_if.start  = 1'b0;
    bus_if.abort  = 1'b0;
    bus_if.golden = ~g;
    check("done_pulse", bus_if.done, 0);
    check("busy_idle", bus_if.busy, 0);
    check("match", bus_if.match, exp == g);
    check("sig_hold", bus_if.sig_out, exp);
    @(negedge clk);
    check("match_hold", bus_if.match, exp == g);
    check("sig_hold2", bus_if.sig_out, exp);
    last_sig = exp;
    dq.delete();
    vq.delete();
  endtask

  initial begin
    int len;
    int abort_at;
    bus_if.start      = 1'b0;
    bus_if.abort      = 1'b0;
    bus_if.mode       = 2'd0;
    bus_if.seed       = 8'h00;
    bus_if.window_len = 8'h00;
    bus_if.data_in    = 8'h00;
    bus_if.data_valid = 1'b0;
    bus_if.golden     = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_sig", bus_if.sig_out, 0);
    check("rst_busy", bus_if.busy, 0);
    check("rst_done", bus_if.done, 0);
    check("rst_match", bus_if.match, 0);
    reset = 1'b1;

    vq = '{1, 1, 1, 1};
    run_window(2'd2, 8'h01, 4, -1, 8'h11);
    check("lfsr_final", last_sig, 8'h11);
    check("lfsr_match", bus_if.match, 1);

    vq = '{1, 1, 1};
    dq = '{8'h0F, 8'hF0, 8'h3C};
    run_window(2'd0, 8'h00, 3, -1, 8'hC4);
    check("xor_final", last_sig, 8'hC3);
    check("xor_match", bus_if.match, 0);

    vq = '{1, 0, 0, 0, 1};
    dq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
    run_window(2'd1, 8'h00, 2, -1, -1);
    check("misr_final", last_sig, 8'h03);

    run_window(2'd1, 8'h5A, 0, -1, 8'h5A);
    check("len0_match", bus_if.match, 1);

    vq = '{1, 1};
    run_window(2'd2, 8'h01, 2, 1, -1);
    check("abort_final", last_sig, 8'h02);
    run_window(2'd0, 8'hAA, 1, -1, -1);

    // asynchronous reset in the middle of a window
    @(negedge clk);
    bus_if.start      = 1'b1;
    bus_if.mode       = 2'd2;
    bus_if.seed       = 8'h01;
    bus_if.window_len = 8'd4;
    @(negedge clk);
    bus_if.start      = 1'b0;
    bus_if.data_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_rst_sig", bus_if.sig_out, 8'h04);
    #2 reset = 1'b0;
    #1;
    check("async_rst_sig", bus_if.sig_out, 0);
    check("async_rst_busy", bus_if.busy, 0);
    check("async_rst_done", bus_if.done, 0);
    bus_if.data_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("rst_hold_done", bus_if.done, 0);
    vq = '{1, 1, 1, 1};
    run_window(2'd2, 8'h01, 4, -1, 8'h11);
    check("post_rst_final", last_sig, 8'h11);

    for (int i = 0; i < 40; i++) begin
      len      = $urandom_range(0, 12);
      abort_at = (len != 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      run_window(2'($urandom), 8'($urandom), len, abort_at, -1);
    end
    run_window(2'd1, 8'($urandom), 255, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
